// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared definitions for the RV32I decode stage.
//   - opcode constants for the RV32I base set
//   - imm_fmt_e: immediate format selected from the opcode
//   - decoded_t: decoded instruction fields registered toward execute
//   - is_rv32i_opcode(): legality check of the 7-bit opcode field
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic        illegal;
  } decoded_t;

  function automatic logic is_rv32i_opcode(input logic [6:0] opc);
    logic legal;
    legal = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// rv32i_imm_gen: combinational immediate format select and assembly.
// Ports:
//   instr  in  32  instruction word
//   fmt    out     immediate format derived from the opcode
//   imm    out 32  sign-extended immediate (0 for R-type, FENCE, SYSTEM, illegal)
module rv32i_imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output imm_fmt_e    fmt,
  output logic [31:0] imm
);

  always_comb begin
    fmt = IMM_NONE;
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: fmt = IMM_I;
      OPC_STORE:                      fmt = IMM_S;
      OPC_BRANCH:                     fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
      OPC_JAL:                        fmt = IMM_J;
      default:                        fmt = IMM_NONE;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'h000};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_decode_stage.sv
// rv32i_decode_stage: RV32I decode stage between fetch and execute.
// Accepts one instruction per valid/ready handshake, presents the source
// register addresses to a 32x32 register file with one-cycle registered read,
// and aligns that read data with the registered decoded fields. Source field 0
// always reads as zero. Single-entry output register with valid/ready.
//
// Optional feature macro: RV32I_DECODE_WB_BYPASS_EN
//   defined   - writeback data matching a nonzero source field replaces stale
//               register-file data (in the accept cycle and while held)
//   undefined - operands come only from the register file (plus x0 rule)
//
// Ports:
//   clock, reset_n (sync, active-low), flush
//   in_valid/in_ready/in_instr/in_pc      fetch side handshake
//   rf_r1_addr/rf_r2_addr, rf_r1_data/rf_r2_data   register-file read port
//   wb_set/wb_addr/wb_data                 writeback snoop
//   out_valid/out_ready and out_* fields   execute side
module rv32i_decode_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rf_r1_addr,
  output logic [4:0]  rf_r2_addr,
  input  logic [31:0] rf_r1_data,
  input  logic [31:0] rf_r2_data,
  input  logic        wb_set,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_rs1_val,
  output logic [31:0] out_rs2_val,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rd,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic        out_funct7_b5,
  output logic        out_illegal
);

  logic        accept;
  logic        out_valid_reg;
  logic        use_hold_reg;
  decoded_t    dec_reg;
  decoded_t    dec_next;
  decoded_t    dec_reset;
  logic [4:0]  r1_addr_reg;
  logic [4:0]  r2_addr_reg;
  imm_fmt_e    fmt;
  logic [31:0] imm;

  logic [4:0]  cur_field [2];
  logic [31:0] rf_data   [2];
  logic [31:0] operand   [2];

  assign in_ready = reset_n & ~flush & (~out_valid_reg | out_ready);
  assign accept   = in_valid & in_ready;

  rv32i_imm_gen u_imm_gen (
    .instr (in_instr),
    .fmt   (fmt),
    .imm   (imm)
  );

  always_comb begin
    dec_next           = '0;
    dec_next.pc        = in_pc;
    dec_next.imm       = imm;
    dec_next.rs1       = in_instr[19:15];
    dec_next.rs2       = in_instr[24:20];
    // S and B formats reuse bits [11:7] for the immediate, not a destination.
    dec_next.rd        = (fmt == IMM_S || fmt == IMM_B) ? 5'd0 : in_instr[11:7];
    dec_next.opcode    = in_instr[6:0];
    dec_next.funct3    = in_instr[14:12];
    dec_next.funct7_b5 = in_instr[30];
    dec_next.illegal   = ~is_rv32i_opcode(in_instr[6:0]);
  end

  always_comb begin
    dec_reset    = '0;
    dec_reset.pc = RESET_PC;
  end

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      out_valid_reg <= 1'b0;
      use_hold_reg  <= 1'b0;
      dec_reg       <= dec_reset;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      use_hold_reg  <= 1'b0;
      dec_reg       <= dec_next;
    end else if (out_valid_reg) begin
      if (out_ready) begin
        out_valid_reg <= 1'b0;
      end else begin
        // Register-file data is only valid in the first cycle; after a
        // stall edge the operands come from the hold registers.
        use_hold_reg <= 1'b1;
      end
    end
  end

  // Read addresses are presented combinationally in the accept cycle so the
  // registered-read data lines up with the first cycle of out_valid.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r1_addr_reg <= 5'd0;
      r2_addr_reg <= 5'd0;
    end else if (accept) begin
      r1_addr_reg <= in_instr[19:15];
      r2_addr_reg <= in_instr[24:20];
    end
  end

  assign rf_r1_addr = accept ? in_instr[19:15] : r1_addr_reg;
  assign rf_r2_addr = accept ? in_instr[24:20] : r2_addr_reg;

  assign cur_field[0] = dec_reg.rs1;
  assign cur_field[1] = dec_reg.rs2;
  assign rf_data[0]   = rf_r1_data;
  assign rf_data[1]   = rf_r2_data;

`ifdef RV32I_DECODE_WB_BYPASS_EN
  logic [4:0] in_field [2];
  assign in_field[0] = in_instr[19:15];
  assign in_field[1] = in_instr[24:20];
`else
  wire unused_wb = &{1'b0, wb_set, wb_addr, wb_data};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      logic [31:0] hold_reg;
      logic [31:0] hold_next;
      logic [31:0] fresh;

`ifdef RV32I_DECODE_WB_BYPASS_EN
      logic        byp_hit_reg;
      logic [31:0] byp_data_reg;

      // The register file returns the pre-write value when a write to the
      // same register lands on the accept edge; capture the writeback instead.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          byp_hit_reg  <= 1'b0;
          byp_data_reg <= '0;
        end else if (accept) begin
          byp_hit_reg  <= wb_set && (wb_addr == in_field[gi]) && (in_field[gi] != 5'd0);
          byp_data_reg <= wb_data;
        end
      end

      assign fresh     = byp_hit_reg ? byp_data_reg : rf_data[gi];
      assign hold_next = (wb_set && (wb_addr == cur_field[gi]) && (cur_field[gi] != 5'd0))
                         ? wb_data : operand[gi];
`else
      assign fresh     = rf_data[gi];
      assign hold_next = operand[gi];
`endif

      assign operand[gi] = (cur_field[gi] == 5'd0) ? 32'd0 :
                           (use_hold_reg ? hold_reg : fresh);

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          hold_reg <= '0;
        end else if (out_valid_reg && !out_ready) begin
          hold_reg <= hold_next;
        end
      end
    end
  endgenerate

  assign out_valid     = out_valid_reg;
  assign out_pc        = dec_reg.pc;
  assign out_rs1_val   = operand[0];
  assign out_rs2_val   = operand[1];
  assign out_imm       = dec_reg.imm;
  assign out_rd        = dec_reg.rd;
  assign out_opcode    = dec_reg.opcode;
  assign out_funct3    = dec_reg.funct3;
  assign out_funct7_b5 = dec_reg.funct7_b5;
  assign out_illegal   = dec_reg.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// tb_rv32i_decode_stage: directed self-checking bench for rv32i_decode_stage.
// Contains a 32x32 register file with one-cycle registered read (old data on
// a same-edge write) and walks a linear sequence of directed steps.
// Expected operand values follow RV32I_DECODE_WB_BYPASS_EN when defined.
module tb_rv32i_decode_stage;

`ifdef RV32I_DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rf_r1_addr;
  logic [4:0]  rf_r2_addr;
  logic [31:0] rf_r1_data;
  logic [31:0] rf_r2_data;
  logic        wb_set;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_rs1_val;
  logic [31:0] out_rs2_val;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7_b5;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rv32i_decode_stage #(.RESET_PC(RESET_PC)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .rf_r1_addr    (rf_r1_addr),
    .rf_r2_addr    (rf_r2_addr),
    .rf_r1_data    (rf_r1_data),
    .rf_r2_data    (rf_r2_data),
    .wb_set        (wb_set),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_rs1_val   (out_rs1_val),
    .out_rs2_val   (out_rs2_val),
    .out_imm       (out_imm),
    .out_rd        (out_rd),
    .out_opcode    (out_opcode),
    .out_funct3    (out_funct3),
    .out_funct7_b5 (out_funct7_b5),
    .out_illegal   (out_illegal)
  );

  // Register file: plain memory (x0 is writable here on purpose).
  logic [31:0] rf_mem [32];
  always @(posedge clock) begin
    rf_r1_data <= rf_mem[rf_r1_addr];
    rf_r2_data <= rf_mem[rf_r2_addr];
    if (wb_set) rf_mem[wb_addr] <= wb_data;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      $display("check %-14s observed %h expected %h ok", tag, observed, expected);
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    wb_set = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_set = 1'b0;
  endtask

  localparam logic [31:0] ADDI = 32'hFFB0_8193;   // addi x3,x1,-5
  localparam logic [31:0] ADD  = 32'h0020_02B3;   // add  x5,x0,x2

  // Back-to-back stream: instr, pc, imm, rd, illegal
  logic [31:0] s_instr [4];
  logic [31:0] s_imm   [4];
  logic [4:0]  s_rd    [4];
  logic        s_ill   [4];

  initial begin
    s_instr[0] = 32'h1234_53B7; s_imm[0] = 32'h1234_5000; s_rd[0] = 5'd7; s_ill[0] = 1'b0; // lui x7
    s_instr[1] = 32'h0020_A423; s_imm[1] = 32'h0000_0008; s_rd[1] = 5'd0; s_ill[1] = 1'b0; // sw x2,8(x1)
    s_instr[2] = 32'hFE20_8EE3; s_imm[2] = 32'hFFFF_FFFC; s_rd[2] = 5'd0; s_ill[2] = 1'b0; // beq x1,x2,-4
    s_instr[3] = 32'h0010_00EF; s_imm[3] = 32'h0000_0800; s_rd[3] = 5'd1; s_ill[3] = 1'b0; // jal x1,0x800

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_instr = ADDI; in_pc = 32'h100;
    out_ready = 1'b1; wb_set = 1'b0; wb_addr = '0; wb_data = '0;

    // Reset held for two edges with in_valid high.
    tick();
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, RESET_PC);
    reset_n = 1'b1; in_valid = 1'b0;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_out_imm", out_imm, 32'd0);
    check("rel_rs1", out_rs1_val, 32'd0);

    rf_write(5'd1, 32'd7);
    rf_write(5'd0, 32'hDEAD);
    rf_write(5'd2, 32'd9);

    // addi x3,x1,-5
    in_valid = 1'b1; in_instr = ADDI; in_pc = 32'h100;
    #1;
    check("addi_r1_addr", {27'd0, rf_r1_addr}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("addi_valid", {31'd0, out_valid}, 32'd1);
    check("addi_rs1", out_rs1_val, 32'd7);
    check("addi_imm", out_imm, 32'hFFFF_FFFB);
    check("addi_rd", {27'd0, out_rd}, 32'd3);
    check("addi_illegal", {31'd0, out_illegal}, 32'd0);
    check("addi_pc", out_pc, 32'h100);
    check("addi_opcode", {25'd0, out_opcode}, 32'h13);
    check("addi_r1_hold", {27'd0, rf_r1_addr}, 32'd1);

    // add x5,x0,x2 accepted on the same edge the addi is consumed.
    in_valid = 1'b1; in_instr = ADD; in_pc = 32'h104;
    #1;
    check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_rs1_x0", out_rs1_val, 32'd0);
    check("add_rs2", out_rs2_val, 32'd9);
    check("add_rd", {27'd0, out_rd}, 32'd5);
    check("add_imm", out_imm, 32'd0);
    check("add_pc", out_pc, 32'h104);
    tick();
    check("add_consumed", {31'd0, out_valid}, 32'd0);

    // Stall three cycles while x1 is rewritten to 0x55.
    in_valid = 1'b1; in_instr = ADDI; in_pc = 32'h108; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("stall_rs1_first", out_rs1_val, 32'd7);
    wb_set = 1'b1; wb_addr = 5'd1; wb_data = 32'h55;
    tick();
    wb_set = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_rs1", out_rs1_val, BYP ? 32'h55 : 32'd7);
      check("stall_pc", out_pc, 32'h108);
      check("stall_imm", out_imm, 32'hFFFF_FFFB);
      #1;
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("stall_released", {31'd0, out_valid}, 32'd0);

    // Accept with a same-cycle writeback to x1.
    in_valid = 1'b1; in_instr = ADDI; in_pc = 32'h10C;
    wb_set = 1'b1; wb_addr = 5'd1; wb_data = 32'h1234;
    tick();
    in_valid = 1'b0; wb_set = 1'b0;
    check("wbacc_rs1", out_rs1_val, BYP ? 32'h1234 : 32'h55);

    // Hold one cycle, then flush with an offered instruction.
    out_ready = 1'b0;
    tick();
    check("pre_flush_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1; in_valid = 1'b1; in_instr = ADD; in_pc = 32'h200;
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_pc", out_pc, RESET_PC);

    // Back-to-back stream, one output per cycle.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = s_instr[i]; in_pc = 32'h300 + 32'(4 * i);
      tick();
      check("s_valid", {31'd0, out_valid}, 32'd1);
      check("s_pc", out_pc, 32'h300 + 32'(4 * i));
      check("s_imm", out_imm, s_imm[i]);
      check("s_rd", {27'd0, out_rd}, {27'd0, s_rd[i]});
      check("s_illegal", {31'd0, out_illegal}, {31'd0, s_ill[i]});
      if (i == 1) begin
        check("sw_rs1", out_rs1_val, 32'h1234);
        check("sw_rs2", out_rs2_val, 32'd9);
      end
    end

    // Illegal opcode: flagged, immediate zero.
    in_instr = 32'h0000_007F; in_pc = 32'h400;
    tick();
    in_valid = 1'b0;
    check("ill_flag", {31'd0, out_illegal}, 32'd1);
    check("ill_imm", out_imm, 32'd0);
    tick();
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
